// File: rtl/avr_data_mem_if.sv
// CPU data-space bus: addr/wen/wdata from the core, rdata back.
// master = CPU side, slave = memory/IO responder side.
interface avr_data_mem_if;
  logic [15:0] addr;
  logic        wen;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  modport master (
    output addr,
    output wen,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wen,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/avr_data_mem.sv
// Data-space responder: sync RAM plus GPIO/timer I/O registers.
// Ports: clk, reset (sync, active-high), bus (slave modport),
//   gpio_in (async pins), gpio_out (PORT), gpio_oe (DDR),
//   timer_irq (TIFR[0] & TIMSK[0]).
// Macro AVR_DATA_MEM_TIMER_EN enables the 8-bit timer block.
module avr_data_mem #(
  parameter logic [15:0] RAM_BASE  = 16'h0100,
  parameter int          RAM_WORDS = 1024,
  parameter logic [15:0] IO_BASE   = 16'h0020
) (
  input  logic       clk,
  input  logic       reset,
  avr_data_mem_if.slave bus,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic [7:0] gpio_oe,
  output logic       timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  // 17-bit bounds so the RAM top never wraps
  localparam logic [16:0] RAM_LO = {1'b0, RAM_BASE};
  localparam logic [16:0] RAM_HI = RAM_LO + 17'(RAM_WORDS);
  localparam logic [16:0] IO_LO  = {1'b0, IO_BASE};
  localparam logic [16:0] IO_HI  = IO_LO + 17'd7;

  logic [16:0]   a17;
  logic          ram_hit;
  logic          io_hit;
  logic [AW-1:0] ram_idx;
  logic [2:0]    io_off;
  logic          wr;
  logic          wr_io;
  logic          wr_ddr;
  logic          wr_port;

  assign a17     = {1'b0, bus.addr};
  assign ram_hit = (a17 >= RAM_LO) && (a17 < RAM_HI);
  assign io_hit  = (a17 >= IO_LO) && (a17 < IO_HI);
  assign ram_idx = AW'(bus.addr - RAM_BASE);
  assign io_off  = 3'(bus.addr - IO_BASE);
  assign wr      = bus.wen && !reset;
  assign wr_io   = wr && io_hit;
  assign wr_ddr  = wr_io && (io_off == 3'd1);
  assign wr_port = wr_io && (io_off == 3'd2);

  logic [7:0] mem_q [RAM_WORDS];
  logic [7:0] ram_rd_q;

  // read-first RAM; contents and read latch are never reset
  always_ff @(posedge clk) begin
    if (wr && ram_hit) mem_q[ram_idx] <= bus.wdata;
    ram_rd_q <= mem_q[ram_idx];
  end

  logic [7:0] pin_s1_q, pin_s2_q;
  logic [7:0] ddr_q, ddr_d;
  logic [7:0] port_q, port_d;
  logic [7:0] io_rd_q, io_rd_d;
  logic       sel_ram_q;

`ifdef AVR_DATA_MEM_TIMER_EN
  logic       wr_tcnt, wr_tccr, wr_tifr, wr_timsk;
  logic [7:0] tcnt_q, tcnt_d;
  logic [2:0] tccr_q, tccr_d;
  logic       tifr_q, tifr_d;
  logic       timsk_q, timsk_d;
  logic [7:0] pre_q, pre_d;
  logic       run;
  logic       tick;
  logic       ovf;
  logic [7:0] term;

  assign wr_tcnt  = wr_io && (io_off == 3'd3);
  assign wr_tccr  = wr_io && (io_off == 3'd4);
  assign wr_tifr  = wr_io && (io_off == 3'd5);
  assign wr_timsk = wr_io && (io_off == 3'd6);

  always_comb begin
    tcnt_d  = tcnt_q;
    tccr_d  = tccr_q;
    tifr_d  = tifr_q;
    timsk_d = timsk_q;
    pre_d   = pre_q;
    run     = 1'b0;
    term    = 8'd0;
    unique case (tccr_q)
      3'd1: begin run = 1'b1; term = 8'd0;   end
      3'd2: begin run = 1'b1; term = 8'd7;   end
      3'd3: begin run = 1'b1; term = 8'd63;  end
      3'd4: begin run = 1'b1; term = 8'd255; end
      default: ;
    endcase
    tick = run && (pre_q == term);
    if (run) pre_d = tick ? 8'd0 : pre_q + 8'd1;
    if (wr_tccr) begin
      pre_d  = 8'd0;
      tccr_d = bus.wdata[2:0];
    end
    // a CPU write to TCNT suppresses both increment and overflow
    ovf = tick && (tcnt_q == 8'hFF) && !wr_tcnt;
    if (wr_tcnt)   tcnt_d = bus.wdata;
    else if (tick) tcnt_d = tcnt_q + 8'd1;
    if (wr_tifr && bus.wdata[0]) tifr_d = 1'b0;
    if (ovf) tifr_d = 1'b1;
    if (wr_timsk) timsk_d = bus.wdata[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q  <= '0;
      tccr_q  <= '0;
      tifr_q  <= 1'b0;
      timsk_q <= 1'b0;
      pre_q   <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      tccr_q  <= tccr_d;
      tifr_q  <= tifr_d;
      timsk_q <= timsk_d;
      pre_q   <= pre_d;
    end
  end

  assign timer_irq = tifr_q & timsk_q;
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    ddr_d   = wr_ddr  ? bus.wdata : ddr_q;
    port_d  = wr_port ? bus.wdata : port_q;
    io_rd_d = 8'h00;
    if (io_hit) begin
      unique case (io_off)
        3'd0: io_rd_d = pin_s2_q;
        3'd1: io_rd_d = ddr_q;
        3'd2: io_rd_d = port_q;
`ifdef AVR_DATA_MEM_TIMER_EN
        3'd3: io_rd_d = tcnt_q;
        3'd4: io_rd_d = {5'b0, tccr_q};
        3'd5: io_rd_d = {7'b0, tifr_q};
        3'd6: io_rd_d = {7'b0, timsk_q};
`endif
        default: io_rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pin_s1_q  <= '0;
      pin_s2_q  <= '0;
      ddr_q     <= '0;
      port_q    <= '0;
      io_rd_q   <= '0;
      sel_ram_q <= 1'b0;
    end else begin
      pin_s1_q  <= gpio_in;
      pin_s2_q  <= pin_s1_q;
      ddr_q     <= ddr_d;
      port_q    <= port_d;
      io_rd_q   <= io_rd_d;
      sel_ram_q <= ram_hit;
    end
  end

  assign bus.rdata = sel_ram_q ? ram_rd_q : io_rd_q;
  assign gpio_out  = port_q;
  assign gpio_oe   = ddr_q;

endmodule

// File: tb/tb_avr_data_mem.sv
// Bench for avr_data_mem: read expectations queued at drive time,
// popped and compared one edge later.
module tb_avr_data_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       timer_irq;

  avr_data_mem_if bus ();

  avr_data_mem dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ck;
    logic [7:0] e;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input logic [15:0] a,
                     input bit w, input logic [7:0] d,
                     input bit ck, input logic [7:0] e,
                     input string tag);
    exp_t x;
    @(negedge clk);
    reset     = r;
    bus.addr  = a;
    bus.wen   = w;
    bus.wdata = d;
    x.ck  = ck;
    x.e   = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e,
                    input string tag);
    cyc(1'b0, a, 1'b0, 8'h00, 1'b1, e, tag);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b0, a, 1'b1, d, 1'b0, 8'h00, "wr");
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.ck) chk(x.tag, {8'h00, bus.rdata}, {8'h00, x.e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    bus.addr  = 16'h0000;
    bus.wen   = 1'b0;
    bus.wdata = 8'h00;
    gpio_in   = 8'h00;

    cyc(1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, "rst0");
    cyc(1'b1, 16'h0000, 1'b0, 8'h00, 1'b1, 8'h00, "rst_rdata");
    settle();
    chk("rst_out", {8'h00, gpio_out}, 16'h0000);
    chk("rst_oe", {8'h00, gpio_oe}, 16'h0000);
    chk("rst_irq", {15'h0, timer_irq}, 16'h0000);

    // RAM basic, bounds, unmapped
    wr(16'h0100, 8'hA5);
    wr(16'h04FF, 8'h3C);
    wr(16'h8100, 8'hEE);
    wr(16'h0500, 8'h55);
    rd(16'h0100, 8'hA5, "ram_lo");
    rd(16'h04FF, 8'h3C, "ram_hi");
    rd(16'h0500, 8'h00, "ram_above");
    rd(16'h8100, 8'h00, "no_alias");
    rd(16'h00FF, 8'h00, "gap_top");
    rd(16'h0027, 8'h00, "gap_io7");
    rd(16'h001F, 8'h00, "below_io");

    // read-first
    wr(16'h0200, 8'h11);
    cyc(1'b0, 16'h0200, 1'b1, 8'h77, 1'b1, 8'h11, "rd_first");
    rd(16'h0200, 8'h77, "rd_new");

    // GPIO
    wr(16'h0021, 8'hF0);
    wr(16'h0022, 8'h5A);
    rd(16'h0021, 8'hF0, "ddr_rd");
    rd(16'h0022, 8'h5A, "port_rd");
    settle();
    chk("gpio_oe", {8'h00, gpio_oe}, 16'h00F0);
    chk("gpio_out", {8'h00, gpio_out}, 16'h005A);
    wr(16'h0020, 8'hFF);
    @(negedge clk);
    gpio_in = 8'hC3;
    bus.addr = 16'h0020;
    bus.wen  = 1'b0;
    begin
      exp_t x;
      x.ck = 1'b1; x.e = 8'h00; x.tag = "pin_s0";
      sb.push_back(x);
    end
    rd(16'h0020, 8'h00, "pin_s1");
    rd(16'h0020, 8'hC3, "pin_s2");

`ifdef AVR_DATA_MEM_TIMER_EN
    // overflow at clk/1
    wr(16'h0023, 8'hFE);
    wr(16'h0026, 8'h01);
    wr(16'h0024, 8'h01);
    rd(16'h0023, 8'hFE, "tcnt_fe");
    rd(16'h0023, 8'hFF, "tcnt_ff");
    settle();
    chk("irq_set", {15'h0, timer_irq}, 16'h0001);
    rd(16'h0023, 8'h00, "tcnt_wrap");
    rd(16'h0025, 8'h01, "tifr_set");
    cyc(1'b0, 16'h0025, 1'b1, 8'h01, 1'b1, 8'h01, "tifr_old");
    settle();
    chk("irq_clr", {15'h0, timer_irq}, 16'h0000);
    wr(16'h0024, 8'h00);

    // clk/8 prescale
    wr(16'h0023, 8'h00);
    wr(16'h0024, 8'h02);
    rd(16'h0024, 8'h02, "tccr_rd");
    for (int i = 2; i <= 8; i++) rd(16'h0023, 8'h00, "pre_hold");
    rd(16'h0023, 8'h01, "pre_tick");
    for (int i = 0; i < 6; i++) rd(16'h0023, 8'h01, "pre_hold2");
    cyc(1'b0, 16'h0023, 1'b1, 8'h40, 1'b1, 8'h01, "tcnt_wtick");
    rd(16'h0023, 8'h40, "tcnt_wins");

    // TIFR clear vs overflow
    wr(16'h0024, 8'h00);
    wr(16'h0023, 8'hFF);
    wr(16'h0024, 8'h01);
    cyc(1'b0, 16'h0025, 1'b1, 8'h01, 1'b1, 8'h00, "tifr_pre");
    rd(16'h0025, 8'h01, "set_wins");
    settle();
    chk("irq_coll", {15'h0, timer_irq}, 16'h0001);
`else
    wr(16'h0023, 8'hFE);
    wr(16'h0026, 8'h01);
    wr(16'h0024, 8'h01);
    wr(16'h0025, 8'h00);
    rd(16'h0023, 8'h00, "tcnt_off");
    rd(16'h0024, 8'h00, "tccr_off");
    rd(16'h0026, 8'h00, "timsk_off");
    settle();
    chk("irq_off", {15'h0, timer_irq}, 16'h0000);
`endif

    // reset mid-run, write with reset discarded
    wr(16'h0022, 8'hFF);
    settle();
    chk("port_ff", {8'h00, gpio_out}, 16'h00FF);
    cyc(1'b1, 16'h0100, 1'b1, 8'h00, 1'b1, 8'h00, "rst_mid");
    settle();
    chk("mid_out", {8'h00, gpio_out}, 16'h0000);
    chk("mid_oe", {8'h00, gpio_oe}, 16'h0000);
    chk("mid_irq", {15'h0, timer_irq}, 16'h0000);
    rd(16'h0100, 8'hA5, "ram_kept");
    rd(16'h0023, 8'h00, "mid_tcnt");
    rd(16'h0024, 8'h00, "mid_tccr");
    rd(16'h0025, 8'h00, "mid_tifr");
    rd(16'h0026, 8'h00, "mid_timsk");
    rd(16'h0022, 8'h00, "mid_port");
    rd(16'h0020, 8'hC3, "mid_pin");
    cyc(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, "idle");
    settle();
    chk("mid_irq2", {15'h0, timer_irq}, 16'h0000);
    chk("sb_drain", 16'(sb.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
